strassen_mm_seq: RTL and testbench
==================================

# strassen_mm_seq

Parametrised, sequential one-level Strassen matrix multiplier computing C = A·B for signed N×N matrices. It replaces the fixed 16×16 flat-port multiplier with a configurable core. A and B are loaded through a write port and C is read through a registered read port. A mode input selects Strassen scheduling (7 block products) or naive scheduling (8 block products) for cross-checking. It sits between the operand loader and the result consumer in the matrix-multiply datapath.

## Interface
- DW, 16: element width of A and B, signed two's complement.
- N, 4: matrix dimension; even, ≥2; H = N/2 is the block size.
- OW, 16: output element width; C is saturated to OW on read.
- CW (localparam): 2·DW + 4 + clog2(N); internal accumulator width.
- AW (localparam): clog2(N·N); element address width.
- clk  in  1  clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begins a run when the block is idle.
- mode  in  1  0 = Strassen, 1 = naive; sampled with start.
- busy  out  1  high while a run is in progress.
- done  out  1  single-cycle pulse at the end of a run.
- ld_valid  in  1  operand write strobe.
- ld_sel  in  1  0 writes A, 1 writes B.
- ld_addr  in  AW  row·N + col.
- ld_data  in  DW  operand value.
- rd_addr  in  AW  C element address, row·N + col.
- rd_data  out  OW  saturated C[rd_addr], registered.
- rd_sat  out  1  high when the rd_data value was clamped.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - When ld_valid=1, the operand at ld_sel[ld_addr] is written with ld_data.
  - When start=1: all C accumulators are cleared, mode is latched, the counters are zeroed, and the state moves to RUN.
- RUN (Strassen): the nested loop is k = 1..7, i, j, l over 0..H-1, with one MAC per cycle. Block operands are formed combinationally with DW+1-bit pre-adds:
  - M1 = (A11+A22)(B11+B22)
  - M2 = (A21+A22)B11
  - M3 = A11(B12−B22)
  - M4 = A22(B21−B11)
  - M5 = (A11+A12)B22
  - M6 = (A21−A11)(B11+B12)
  - M7 = (A12−A22)(B21+B22)
- Mk element (i,j) accumulates over l; the M matrices are never stored.
  - When l=H-1 completes, the finished value is scatter-added into the C accumulators with signs:
  - C11 = M1+M4−M5+M7
  - C12 = M3+M5
  - C21 = M2+M4
  - C22 = M1−M2+M3+M6
- RUN (naive): the loop is i, j, l over 0..N-1, with C[i][j] += A[i][l]·B[l][j].
- Product pipeline: the multiplier output is registered (1 stage). After the last RUN cycle, one DRAIN cycle retires the final product. The state then returns to IDLE with done=1.
- While busy: ld_valid and start are ignored; A, B and mode cannot change.
- Read port: rd_data = clamp(Cacc[rd_addr], −2^(OW−1), 2^(OW−1)−1), registered one cycle after rd_addr. rd_sat is set in the same cycle when clamping occurs. Reads while busy return partial sums and are not meaningful.
- Arithmetic: all sums are full-precision signed in CW bits; no wrap is possible within CW.

## Timing
- Reset (rst_n=0, any state, effective immediately):
  - The state goes to IDLE.
  - busy=0, done=0, rd_data=0, rd_sat=0.
  - A, B and C accumulators are cleared to 0.
  - A run in progress is aborted and done is never pulsed for it.
- R = 7·H³ (mode 0) or N³ (mode 1).
- Let the start edge be t0:
  - busy=1 in the cycles following edges t0 … t0+R.
  - done=1 and busy=0 after edge t0+R+1.
  - Start-to-done latency is R+1 edges.
- done lasts exactly 1 cycle.
- A start asserted in the same cycle that done is high is accepted, giving back-to-back runs.
- A ld_valid write in the same cycle as an accepted start is performed before the run samples operands.
- Read latency: 1 cycle, independent of state.

## Test plan
- Identity, N=4, mode 0: A=I, B[r][c]=4r+c → C equals B for all 16 addresses, rd_sat=0; done 57 edges after start (R=56).
- Cross-mode: random A and B in [−100,100], N=4 → mode 0 and mode 1 give identical C that matches the golden model; mode 1 done after 65 edges.
- Saturation, DW=OW=16: A=B=all −32768 → every C element is 2^32 true; rd_data=32767 and rd_sat=1. A=all −32768, B=all 32767 → rd_data=−32768 and rd_sat=1.
- N=2: A=[[1,2],[3,4]], B=[[5,6],[7,8]] → C=[[19,22],[43,50]]; done 8 edges after start.
- Busy protection: during RUN, write A[0]=99 and pulse start again → result unchanged from the pre-run operands; exactly one done pulse.
- Reset mid-run: drop rst_n 20 cycles into RUN → busy=0 immediately; no done pulse; all reads return 0. After reloading the operands, a new run produces the correct C.

Source files
------------

// File: rtl/strassen_mm_seq.sv
// strassen_mm_seq: sequential one-level Strassen (or naive) N x N signed
// matrix multiplier with a write port for A/B and a registered, saturating
// read port for C. One MAC per cycle, one registered product stage.
module strassen_mm_seq #(
  parameter int DW = 16,
  parameter int N  = 4,
  parameter int OW = 16,
  localparam int CW = 2 * DW + 4 + $clog2(N),
  localparam int AW = $clog2(N * N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  output logic          busy,
  output logic          done,
  input  logic          ld_valid,
  input  logic          ld_sel,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic [AW-1:0] rd_addr,
  output logic [OW-1:0] rd_data,
  output logic          rd_sat
);

  localparam int H  = N / 2;
  localparam int IW = $clog2(N);
  localparam int PW = 2 * DW + 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state_q, state_d;
  logic mode_q, mode_d, done_q, done_d;
  logic [2:0] k_q, k_d, pk_q, pk_d;
  logic [IW-1:0] i_q, i_d, j_q, j_d, l_q, l_d, pi_q, pi_d, pj_q, pj_d;
  logic pv_q, pv_d, plast_q, plast_d;
  logic signed [PW-1:0] prod_q, prod_d;
  logic signed [CW-1:0] macc_q, macc_d, m_sum, c_rd;
  logic signed [DW-1:0] a_q [N*N], a_d [N*N], b_q [N*N], b_d [N*N];
  logic signed [CW-1:0] c_q [N*N], c_d [N*N];
  logic [OW-1:0] rd_data_q, rd_data_d;
  logic rd_sat_q, rd_sat_d;
  logic [IW-1:0] lim;
  logic last, issue, start_ok, ovf;
  logic [AW-1:0] idx11, idx12, idx21, idx22;
  logic signed [DW:0] a11, a12, a21, a22, b11, b12, b21, b22, op_a, op_b;

  function automatic logic [AW-1:0] addr(input int r, input int c);
    return AW'(r * N + c);
  endfunction

  function automatic logic signed [DW:0] sx(input logic [DW-1:0] x);
    return {x[DW-1], x};
  endfunction

  assign lim  = mode_q ? IW'(N - 1) : IW'(H - 1);
  assign last = (l_q == lim) && (j_q == lim) && (i_q == lim) && (mode_q || k_q == 3'd6);
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign rd_data = rd_data_q;
  assign rd_sat  = rd_sat_q;

  // Control FSM and loop counters: issue one MAC per RUN cycle, drain one cycle.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    k_d      = k_q;
    i_d      = i_q;
    j_d      = j_q;
    l_d      = l_q;
    done_d   = 1'b0;
    issue    = 1'b0;
    start_ok = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        start_ok = 1'b1;
        state_d  = RUN;
        mode_d   = mode;
        k_d      = '0;
        i_d      = '0;
        j_d      = '0;
        l_d      = '0;
      end
      RUN: begin
        issue = 1'b1;
        if (l_q != lim) l_d = l_q + IW'(1);
        else begin
          l_d = '0;
          if (j_q != lim) j_d = j_q + IW'(1);
          else begin
            j_d = '0;
            if (i_q != lim) i_d = i_q + IW'(1);
            else begin
              i_d = '0;
              k_d = k_q + 3'd1;
            end
          end
        end
        if (last) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand selection with block pre-adds; naive mode reuses the A11/B11 taps.
  always_comb begin
    a11 = sx(a_q[addr(int'(i_q), int'(l_q))]);
    a12 = sx(a_q[addr(int'(i_q), H + int'(l_q))]);
    a21 = sx(a_q[addr(H + int'(i_q), int'(l_q))]);
    a22 = sx(a_q[addr(H + int'(i_q), H + int'(l_q))]);
    b11 = sx(b_q[addr(int'(l_q), int'(j_q))]);
    b12 = sx(b_q[addr(int'(l_q), H + int'(j_q))]);
    b21 = sx(b_q[addr(H + int'(l_q), int'(j_q))]);
    b22 = sx(b_q[addr(H + int'(l_q), H + int'(j_q))]);
    op_a = a11;
    op_b = b11;
    if (!mode_q) begin
      case (k_q)
        3'd0: begin op_a = a11 + a22; op_b = b11 + b22; end
        3'd1: begin op_a = a21 + a22; op_b = b11;       end
        3'd2: begin op_a = a11;       op_b = b12 - b22; end
        3'd3: begin op_a = a22;       op_b = b21 - b11; end
        3'd4: begin op_a = a11 + a12; op_b = b22;       end
        3'd5: begin op_a = a21 - a11; op_b = b11 + b12; end
        default: begin op_a = a12 - a22; op_b = b21 + b22; end
      endcase
    end
    prod_d  = PW'(op_a) * PW'(op_b);
    pv_d    = issue;
    plast_d = (l_q == lim);
    pk_d    = k_q;
    pi_d    = i_q;
    pj_d    = j_q;
  end

  // Operand writes are only honoured while idle.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (state_q == IDLE && ld_valid) begin
      if (ld_sel) b_d[ld_addr] = ld_data;
      else        a_d[ld_addr] = ld_data;
    end
  end

  // Retire the registered product: accumulate Mk and scatter it into C blocks.
  always_comb begin
    c_d    = c_q;
    macc_d = macc_q;
    m_sum  = macc_q + CW'(prod_q);
    idx11  = addr(int'(pi_q), int'(pj_q));
    idx12  = addr(int'(pi_q), H + int'(pj_q));
    idx21  = addr(H + int'(pi_q), int'(pj_q));
    idx22  = addr(H + int'(pi_q), H + int'(pj_q));
    if (start_ok) begin
      for (int n = 0; n < N * N; n++) c_d[n] = '0;
      macc_d = '0;
    end else if (pv_q) begin
      if (mode_q) c_d[idx11] = c_q[idx11] + CW'(prod_q);
      else if (!plast_q) macc_d = m_sum;
      else begin
        macc_d = '0;
        case (pk_q)
          3'd0: begin c_d[idx11] = c_d[idx11] + m_sum; c_d[idx22] = c_d[idx22] + m_sum; end
          3'd1: begin c_d[idx21] = c_d[idx21] + m_sum; c_d[idx22] = c_d[idx22] - m_sum; end
          3'd2: begin c_d[idx12] = c_d[idx12] + m_sum; c_d[idx22] = c_d[idx22] + m_sum; end
          3'd3: begin c_d[idx11] = c_d[idx11] + m_sum; c_d[idx21] = c_d[idx21] + m_sum; end
          3'd4: begin c_d[idx11] = c_d[idx11] - m_sum; c_d[idx12] = c_d[idx12] + m_sum; end
          3'd5: c_d[idx22] = c_d[idx22] + m_sum;
          default: c_d[idx11] = c_d[idx11] + m_sum;
        endcase
      end
    end
  end

  // Saturating read of the addressed accumulator.
  always_comb begin
    c_rd = c_q[rd_addr];
    ovf  = !((&c_rd[CW-1:OW-1]) || !(|c_rd[CW-1:OW-1]));
    rd_sat_d  = ovf;
    rd_data_d = c_rd[OW-1:0];
    if (ovf) rd_data_d = c_rd[CW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
  end

  // State registers with asynchronous clear of everything, storage included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      done_q    <= 1'b0;
      k_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      l_q       <= '0;
      pk_q      <= '0;
      pi_q      <= '0;
      pj_q      <= '0;
      pv_q      <= 1'b0;
      plast_q   <= 1'b0;
      prod_q    <= '0;
      macc_q    <= '0;
      rd_data_q <= '0;
      rd_sat_q  <= 1'b0;
      for (int n = 0; n < N * N; n++) begin
        a_q[n] <= '0;
        b_q[n] <= '0;
        c_q[n] <= '0;
      end
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      done_q    <= done_d;
      k_q       <= k_d;
      i_q       <= i_d;
      j_q       <= j_d;
      l_q       <= l_d;
      pk_q      <= pk_d;
      pi_q      <= pi_d;
      pj_q      <= pj_d;
      pv_q      <= pv_d;
      plast_q   <= plast_d;
      prod_q    <= prod_d;
      macc_q    <= macc_d;
      rd_data_q <= rd_data_d;
      rd_sat_q  <= rd_sat_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
    end
  end

endmodule

// File: tb/tb_strassen_mm_seq.sv
// tb_strassen_mm_seq: directed bench for strassen_mm_seq (N=4 main instance,
// N=2 secondary instance) against a plain row-by-column golden product.
module tb_strassen_mm_seq;

  logic clk = 1'b0;
  logic rst_n, start, mode, ld_valid, ld_sel, busy, done, rd_sat;
  logic [3:0] ld_addr, rd_addr;
  logic [15:0] ld_data;
  logic signed [15:0] rd_data;

  logic start2, ld_valid2, ld_sel2, busy2, done2, rd_sat2;
  logic [1:0] ld_addr2, rd_addr2;
  logic [15:0] ld_data2;
  logic signed [15:0] rd_data2;

  int errors = 0;
  int checks = 0;
  int ma [16];
  int mb [16];
  longint gold [16];
  int lat, dcount;

  strassen_mm_seq #(.DW(16), .N(4), .OW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .busy(busy), .done(done),
    .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_sat(rd_sat)
  );

  strassen_mm_seq #(.DW(16), .N(2), .OW(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode(1'b0), .busy(busy2), .done(done2),
    .ld_valid(ld_valid2), .ld_sel(ld_sel2), .ld_addr(ld_addr2), .ld_data(ld_data2),
    .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_sat(rd_sat2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one operand write into the N=4 instance; starts and ends on a falling edge
  task automatic applyStimulus(input logic sel, input int adr, input int val);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_addr  = 4'(adr);
    ld_data  = 16'(val);
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic load_all();
    for (int n = 0; n < 16; n++) begin
      applyStimulus(1'b0, n, ma[n]);
      applyStimulus(1'b1, n, mb[n]);
    end
  endtask

  task automatic compute_gold();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        gold[r*4+c] = 0;
        for (int l = 0; l < 4; l++)
          gold[r*4+c] += longint'(ma[r*4+l]) * longint'(mb[l*4+c]);
      end
  endtask

  function automatic longint clamp16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic run_mm(input logic m, output int edges);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    checkOutput("busy_in_run", busy, 1);
    while (!done && edges < 200) begin
      @(negedge clk);
      edges++;
    end
    @(negedge clk);
    checkOutput("done_one_cycle", done, 0);
    checkOutput("busy_after_done", busy, 0);
  endtask

  task automatic check_c(input string tag);
    for (int n = 0; n < 16; n++) begin
      rd_addr = 4'(n);
      @(negedge clk);
      checkOutput($sformatf("%s_data%0d", tag, n), rd_data, clamp16(gold[n]));
      checkOutput($sformatf("%s_sat%0d", tag, n), rd_sat,
                  (gold[n] > 32767 || gold[n] < -32768) ? 1 : 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; ld_valid = 1'b0; ld_sel = 1'b0;
    ld_addr = '0; ld_data = '0; rd_addr = '0;
    start2 = 1'b0; ld_valid2 = 1'b0; ld_sel2 = 1'b0; ld_addr2 = '0; ld_data2 = '0; rd_addr2 = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_rd_data", rd_data, 0);
    checkOutput("rst_rd_sat", rd_sat, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // identity A, ramp B, Strassen mode
    for (int n = 0; n < 16; n++) begin
      ma[n] = (n / 4 == n % 4) ? 1 : 0;
      mb[n] = n;
    end
    load_all();
    compute_gold();
    run_mm(1'b0, lat);
    checkOutput("lat_ident_strassen", lat, 57);
    check_c("ident");

    // random operands, both scheduling modes
    for (int n = 0; n < 16; n++) begin
      ma[n] = int'($urandom_range(200, 0)) - 100;
      mb[n] = int'($urandom_range(200, 0)) - 100;
    end
    load_all();
    compute_gold();
    run_mm(1'b0, lat);
    checkOutput("lat_rand_strassen", lat, 57);
    check_c("rand_m0");
    run_mm(1'b1, lat);
    checkOutput("lat_rand_naive", lat, 65);
    check_c("rand_m1");

    // saturation high and low
    for (int n = 0; n < 16; n++) begin
      ma[n] = -32768;
      mb[n] = -32768;
    end
    load_all();
    compute_gold();
    run_mm(1'b0, lat);
    check_c("sat_pos");
    for (int n = 0; n < 16; n++) mb[n] = 32767;
    load_all();
    compute_gold();
    run_mm(1'b0, lat);
    check_c("sat_neg");

    // busy protection: stray write and start during RUN are ignored
    for (int n = 0; n < 16; n++) begin
      ma[n] = (n / 4 == n % 4) ? 1 : 0;
      mb[n] = 3 * n - 20;
    end
    load_all();
    compute_gold();
    start = 1'b1;
    mode  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    dcount = 0;
    for (int c = 0; c < 10; c++) @(negedge clk);
    ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 4'd0; ld_data = 16'd99; start = 1'b1;
    @(negedge clk);
    ld_valid = 1'b0; start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (done) dcount++;
      @(negedge clk);
    end
    checkOutput("busy_prot_done_count", dcount, 1);
    check_c("busy_prot");

    // reset in the middle of a run
    for (int n = 0; n < 16; n++) begin
      ma[n] = int'($urandom_range(200, 0)) - 100;
      mb[n] = int'($urandom_range(200, 0)) - 100;
    end
    load_all();
    start = 1'b1;
    mode  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20; c++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_rd_data", rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int c = 0; c < 60; c++) begin
      if (done) dcount++;
      @(negedge clk);
    end
    checkOutput("midrst_no_done", dcount, 0);
    for (int n = 0; n < 16; n++) gold[n] = 0;
    check_c("midrst_zero");
    run_mm(1'b0, lat);
    check_c("midrst_cleared_ops");
    load_all();
    compute_gold();
    run_mm(1'b0, lat);
    check_c("midrst_rerun");

    // N=2 instance: [[1,2],[3,4]] x [[5,6],[7,8]]
    for (int n = 0; n < 8; n++) begin
      ld_valid2 = 1'b1;
      ld_sel2   = (n >= 4);
      ld_addr2  = 2'(n % 4);
      ld_data2  = 16'(n + 1);
      @(negedge clk);
    end
    ld_valid2 = 1'b0;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat = 0;
    while (!done2 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("n2_latency", lat, 8);
    for (int n = 0; n < 4; n++) begin
      rd_addr2 = 2'(n);
      @(negedge clk);
      checkOutput($sformatf("n2_c%0d", n), rd_data2,
                  (n == 0) ? 19 : (n == 1) ? 22 : (n == 2) ? 43 : 50);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
